// File: rtl/data_feed_pkg.sv
// Shared types and helpers for the data feed stage.
//   feed_state_t : issue FSM states (idle / inter-pulse gap)
//   GAP_W        : width of the gap counter (supports GAP 0..15)
//   ptr_w()      : pointer width for a FIFO of a given depth (min 1 bit)
package data_feed_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_GAP
  } feed_state_t;

  localparam int unsigned GAP_W = 4;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_feed_fifo.sv
// DEPTH-entry FIFO with explicit pointer wrap (DEPTH need not be a power of 2).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clr            synchronous discard of all contents
//   push, wr_data  write request and word (caller guarantees not full)
//   pop            read request (caller guarantees not empty)
//   rd_data        head word, combinational from storage
//   level          occupancy
//   full, empty    occupancy flags
module data_feed_fifo
  import data_feed_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 10,
  localparam int unsigned PTR_W = ptr_w(DEPTH),
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (!rst && !clr && push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;
  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);

endmodule

// File: rtl/data_feed_stage.sv
// Upstream feeder: buffers producer words and replays them to a consumer as a
// registered data bus with a one-cycle en strobe per word, with GAP forced idle
// cycles between strobes.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_data, in_valid  producer word / valid
//   in_ready           FIFO can accept (push = in_valid & in_ready)
//   pause              hold issue, FIFO keeps filling
//   flush              discard contents, abort pacing, clear issued
//   data, en           consumer word (holds last value) and strobe
//   level              FIFO occupancy
//   issued             en pulse count since reset/flush (wraps)
module data_feed_stage
  import data_feed_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned GAP   = 0,
  localparam int unsigned DEPTH = WIDTH + 2,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             pause,
  input  logic             flush,
  output logic [WIDTH-1:0] data,
  output logic             en,
  output logic [LVL_W-1:0] level,
  output logic [31:0]      issued
);

  feed_state_t      state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             en_q, en_d;
  logic [31:0]      issued_q, issued_d;

  logic [WIDTH-1:0] head;
  logic             full, empty, push, pop;

  assign in_ready = ~full & ~flush & ~rst;
  assign push     = in_valid & in_ready;
  // Pop looks at pre-push occupancy, so a word written this cycle is never
  // popped in the same cycle.
  assign pop      = (state_q == ST_IDLE) & ~empty & ~pause & ~flush & ~rst;

  data_feed_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    data_d    = data_q;
    en_d      = 1'b0;
    issued_d  = issued_q;
    if (flush) begin
      state_d   = ST_IDLE;
      gap_cnt_d = '0;
      issued_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            data_d   = head;
            en_d     = 1'b1;
            issued_d = issued_q + 32'd1;
            if (GAP != 0) begin
              state_d   = ST_GAP;
              gap_cnt_d = GAP_W'(GAP);
            end
          end
        end
        ST_GAP: begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
          if (gap_cnt_q == GAP_W'(1)) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= '0;
      data_q    <= '0;
      en_q      <= 1'b0;
      issued_q  <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      data_q    <= data_d;
      en_q      <= en_d;
      issued_q  <= issued_d;
    end
  end

  always_ff @(posedge clk) begin
    assert (GAP < 16 && DEPTH >= 2);
  end

  assign data   = data_q;
  assign en     = en_q;
  assign issued = issued_q;

endmodule

// File: tb/tb_data_feed_stage.sv
module tb_data_feed_stage;

  typedef logic [7:0] wq_t[$];

  logic       clk = 1'b0;
  logic       rst, in_valid, pause, flush;
  logic [7:0] in_data;

  logic       in_ready0, en0, in_ready3, en3;
  logic [7:0] data0, data3;
  logic [3:0] level0, level3;
  logic [31:0] issued0, issued3;

  always #5 clk = ~clk;

  data_feed_stage #(.WIDTH(8), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .pause(pause), .flush(flush), .data(data0),
    .en(en0), .level(level0), .issued(issued0)
  );

  data_feed_stage #(.WIDTH(8), .GAP(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready3), .pause(pause), .flush(flush), .data(data3),
    .en(en3), .level(level3), .issued(issued3)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: a word queue per instance plus a cooldown giving the
  // minimum number of edges before the next issue is allowed.
  wq_t         mq0, mq1;
  int unsigned m_cool[2];
  int unsigned m_issued[2];
  int unsigned m_gap[2] = '{0, 3};
  logic        m_en[2];
  logic [7:0]  m_data[2];
  int unsigned cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit exp_rdy(input int k);
    int unsigned sz;
    sz = (k == 0) ? mq0.size() : mq1.size();
    return !rst && !flush && (sz != 10);
  endfunction

  task automatic model_edge(input int k);
    wq_t q;
    bit  rdy;
    if (k == 0) q = mq0; else q = mq1;
    rdy = !rst && !flush && (q.size() != 10);
    if (rst) begin
      q.delete();
      m_data[k] = 8'h00; m_en[k] = 1'b0; m_issued[k] = 0; m_cool[k] = 0;
    end else if (flush) begin
      q.delete();
      m_en[k] = 1'b0; m_issued[k] = 0; m_cool[k] = 0;
    end else begin
      if (q.size() > 0 && !pause && m_cool[k] == 0) begin
        m_data[k] = q.pop_front();
        m_en[k]   = 1'b1;
        m_issued[k]++;
        m_cool[k] = m_gap[k];
      end else begin
        m_en[k] = 1'b0;
        if (m_cool[k] > 0) m_cool[k]--;
      end
      if (in_valid && rdy) q.push_back(in_data);
    end
    if (k == 0) mq0 = q; else mq1 = q;
  endtask

  task automatic tick();
    #1;
    chk("in_ready0", in_ready0, exp_rdy(0));
    chk("in_ready3", in_ready3, exp_rdy(1));
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    cyc++;
    chk("en0", en0, m_en[0]);
    chk("data0", data0, m_data[0]);
    chk("level0", level0, mq0.size());
    chk("issued0", issued0, m_issued[0]);
    chk("en3", en3, m_en[1]);
    chk("data3", data3, m_data[1]);
    chk("level3", level3, mq1.size());
    chk("issued3", issued3, m_issued[1]);
  endtask

  task automatic drive(input bit r, input bit v, input logic [7:0] d, input bit p, input bit f);
    rst = r; in_valid = v; in_data = d; pause = p; flush = f;
  endtask

  task automatic do_reset();
    drive(1, 0, 8'h00, 0, 0);
    tick();
    drive(0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    wq_t         got;
    int unsigned last_en, n_en, next_w;
    bit          acc;

    drive(1, 0, 8'h00, 0, 0);
    tick();
    tick();
    chk("rst_level0", level0, 0);
    chk("rst_issued0", issued0, 0);
    drive(0, 0, 8'h00, 0, 0);
    tick();

    // Single word, GAP=0: strobe two edges after the push
    drive(0, 1, 8'hA5, 0, 0);
    tick();
    drive(0, 0, 8'h00, 0, 0);
    tick();
    chk("t1_en", en0, 1);
    chk("t1_data", data0, 8'hA5);
    tick();
    chk("t1_issued", issued0, 1);
    chk("t1_level", level0, 0);

    // Fill past capacity while paused, then drain back-to-back
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 8'(i), 1, 0);
      tick();
    end
    chk("t2_level_full", level0, 10);
    drive(0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_burst_en", en0, 1);
      chk("t2_burst_data", data0, 8'(i));
    end
    tick();
    chk("t2_done_en", en0, 0);

    // GAP=3 pacing: pulses exactly 4 cycles apart
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 8'(8'h50 + i), 1, 0);
      tick();
    end
    drive(0, 0, 8'h00, 0, 0);
    n_en = 0; last_en = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (en3) begin
        if (n_en > 0) chk("t3_spacing", cyc - last_en, 4);
        last_en = cyc;
        n_en++;
      end
    end
    chk("t3_pulses", n_en, 4);
    chk("t3_issued", issued3, 4);

    // Flush mid-issue with a concurrent push
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 8'(8'h10 + i), 1, 0);
      tick();
    end
    drive(0, 0, 8'h00, 0, 0);
    tick(); tick(); tick();
    drive(0, 1, 8'h77, 0, 1);
    tick();
    chk("t4_level", level0, 0);
    chk("t4_issued", issued0, 0);
    chk("t4_en", en0, 0);
    chk("t4_data_kept", data0, 8'h12);
    drive(0, 0, 8'h00, 0, 0);
    tick(); tick();
    chk("t4_no_store", level0, 0);
    chk("t4_no_issue", issued0, 0);

    // Stream 25 words with random pause across pointer wrap
    do_reset();
    got.delete();
    next_w = 0;
    for (int i = 0; i < 400 && got.size() < 25; i++) begin
      drive(0, (next_w < 25) && ($urandom_range(0, 3) != 0), 8'(8'h30 + next_w),
            $urandom_range(0, 2) == 0, 0);
      acc = in_valid && exp_rdy(0);
      tick();
      if (acc) next_w++;
      if (en0) got.push_back(data0);
    end
    chk("t5_count", got.size(), 25);
    for (int i = 0; i < got.size(); i++) chk("t5_order", got[i], 8'(8'h30 + i));

    // Reset while GAP instance is pacing with 5 words queued
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 8'(8'h60 + i), 1, 0);
      tick();
    end
    drive(0, 0, 8'h00, 0, 0);
    tick();
    tick();
    chk("t6_pre_level", level3, 5);
    drive(1, 0, 8'h00, 0, 0);
    tick();
    chk("t6_level", level3, 0);
    chk("t6_en", en3, 0);
    chk("t6_data", data3, 0);
    chk("t6_issued", issued3, 0);
    drive(0, 1, 8'h3C, 0, 0);
    tick();
    drive(0, 0, 8'h00, 0, 0);
    tick();
    chk("t6_reissue_en", en3, 1);
    chk("t6_reissue_data", data3, 8'h3C);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, 8'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
